// File: rtl/mark_table.sv
// mark_table: used-number bookkeeping for a 9x9 sudoku grid.
// Three 81-bit bitmaps record which numbers are already used in each
// row, column and 3x3 box. A small scanner walks the candidates of one
// cell upward from a start value and reports the first free one.
module mark_table (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mark,
  input  logic       i_unmark,
  input  logic [6:0] i_addr_mark_row,
  input  logic [6:0] i_addr_mark_col,
  input  logic [6:0] i_addr_mark_matrix,
  input  logic       i_clear,
  input  logic       i_start,
  input  logic [3:0] i_row,
  input  logic [3:0] i_col,
  input  logic [3:0] i_num_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_found,
  output logic [3:0] o_num
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] LAST_IDX = 7'd80;

  state_t      r_state;
  state_t      w_next_state;

  logic [80:0] r_row_map;
  logic [80:0] r_col_map;
  logic [80:0] r_box_map;

  logic [3:0]  r_row;
  logic [3:0]  r_col;
  logic [3:0]  r_box;
  logic [3:0]  r_cur;
  logic        r_found;
  logic [3:0]  r_num;
  logic        r_done;

  logic        w_start_valid;
  logic [3:0]  w_start_box;
  logic [6:0]  w_row_idx;
  logic [6:0]  w_col_idx;
  logic [6:0]  w_box_idx;
  logic        w_cur_free;

  // Maps a row or column coordinate (0..8) to its band/stack index (0..2).
  function automatic logic [3:0] f_div3(input logic [3:0] v);
    if (v >= 4'd6) begin
      f_div3 = 4'd2;
    end else if (v >= 4'd3) begin
      f_div3 = 4'd1;
    end else begin
      f_div3 = 4'd0;
    end
  endfunction

  // A start request is only scanned when the cell and first candidate are in range.
  assign w_start_valid = (i_row <= 4'd8) && (i_col <= 4'd8) &&
                         (i_num_start >= 4'd1) && (i_num_start <= 4'd9);

  // Box number of the requested cell, counted row-major across the 3x3 boxes.
  assign w_start_box = (f_div3(i_row) * 4'd3) + f_div3(i_col);

  // Bitmap indices of the candidate currently under test; only meaningful in SCAN,
  // where the latched coordinates are guaranteed in range and cur is 1..9.
  assign w_row_idx = ({3'b000, r_row} * 7'd9) + {3'b000, r_cur} - 7'd1;
  assign w_col_idx = ({3'b000, r_col} * 7'd9) + {3'b000, r_cur} - 7'd1;
  assign w_box_idx = ({3'b000, r_box} * 7'd9) + {3'b000, r_cur} - 7'd1;

  // The candidate is free only when none of its three groups already uses it.
  // Reads come straight from the registers, so an update lands one edge later.
  assign w_cur_free = ~(r_row_map[w_row_idx] | r_col_map[w_col_idx] | r_box_map[w_box_idx]);

  // Bitmap storage: clear wipes everything, mark beats unmark, and an
  // out-of-range address only suppresses the update of its own bitmap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_map <= '0;
      r_col_map <= '0;
      r_box_map <= '0;
    end else if (i_clear) begin
      r_row_map <= '0;
      r_col_map <= '0;
      r_box_map <= '0;
    end else if (i_mark) begin
      if (i_addr_mark_row <= LAST_IDX) begin
        r_row_map[i_addr_mark_row] <= 1'b1;
      end
      if (i_addr_mark_col <= LAST_IDX) begin
        r_col_map[i_addr_mark_col] <= 1'b1;
      end
      if (i_addr_mark_matrix <= LAST_IDX) begin
        r_box_map[i_addr_mark_matrix] <= 1'b1;
      end
    end else if (i_unmark) begin
      if (i_addr_mark_row <= LAST_IDX) begin
        r_row_map[i_addr_mark_row] <= 1'b0;
      end
      if (i_addr_mark_col <= LAST_IDX) begin
        r_col_map[i_addr_mark_col] <= 1'b0;
      end
      if (i_addr_mark_matrix <= LAST_IDX) begin
        r_box_map[i_addr_mark_matrix] <= 1'b0;
      end
    end
  end

  // Scanner state register; clear aborts straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (i_clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Scanner next-state logic: stop at the first free candidate or after testing 9.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = w_start_valid ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (w_cur_free || (r_cur == 4'd9)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Scan datapath: latch the request, walk cur upward, and register the result.
  // The done pulse is registered off the DONE state so it appears one cycle
  // after the deciding edge, and an abort in DONE never produces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row   <= '0;
      r_col   <= '0;
      r_box   <= '0;
      r_cur   <= '0;
      r_found <= 1'b0;
      r_num   <= '0;
      r_done  <= 1'b0;
    end else if (i_clear) begin
      r_found <= 1'b0;
      r_num   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_row   <= i_row;
            r_col   <= i_col;
            r_box   <= w_start_box;
            r_cur   <= i_num_start;
            r_found <= 1'b0;
            r_num   <= '0;
          end
        end
        SCAN: begin
          if (w_cur_free) begin
            r_found <= 1'b1;
            r_num   <= r_cur;
          end else if (r_cur == 4'd9) begin
            r_found <= 1'b0;
            r_num   <= '0;
          end else begin
            r_cur <= r_cur + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy  = (r_state == SCAN) || (r_state == DONE);
  assign o_done  = r_done;
  assign o_found = r_found;
  assign o_num   = r_num;

endmodule
